// File: rtl/microc_pkg.sv
// Shared constants for the microc datapath: ALU op codes and instruction field layout.
package microc_pkg;
  localparam int IW         = 16;
  localparam int OPCODE_W   = 6;
  localparam int OPCODE_LSB = 10;
  localparam int RA_W       = 4;
  localparam int RA1_LSB    = 8;
  localparam int RA2_LSB    = 4;
  localparam int WA3_LSB    = 0;
  localparam int IMM_LSB    = 4;
  localparam int IMM_W      = 8;
  localparam int NREGS      = 16;

  localparam logic [2:0] ALU_PASSA = 3'b000;
  localparam logic [2:0] ALU_NOTA  = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_NEGA  = 3'b110;
  localparam logic [2:0] ALU_NEGB  = 3'b111;
endpackage

// File: rtl/microc_stack_pc_stack.sv
// Return-address stack: pointer-indexed storage, full/empty decoded from the pointer,
// sticky error on overflow, underflow or simultaneous push/pop (pop wins).
module pc_stack #(
  parameter int PCW         = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic [PCW-1:0] push_data,
  output logic [PCW-1:0] top,
  output logic           full,
  output logic           empty,
  output logic           err
);
  localparam int PW = $clog2(STACK_DEPTH);

  logic [PW:0]    ptr;
  logic [PW:0]    ptr_m1;
  logic [PCW-1:0] mem [STACK_DEPTH];
  logic           do_push, do_pop;

  assign full    = (ptr == (PW+1)'(STACK_DEPTH));
  assign empty   = (ptr == '0);
  assign ptr_m1  = ptr - (PW+1)'(1);
  assign top     = mem[ptr_m1[PW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && !pop && !full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      err <= 1'b0;
    end else begin
      if (do_pop)       ptr <= ptr_m1;
      else if (do_push) ptr <= ptr + (PW+1)'(1);
      if ((push && pop) || (push && full) || (pop && empty)) err <= 1'b1;
    end
  end

  // Storage is not reset; only entries below the pointer are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[ptr[PW-1:0]] <= push_data;
  end
endmodule

// File: rtl/microc_stack.sv
// Single-cycle microcontroller datapath with external program ROM port and CALL/RET stack.
// Define MICROC_CARRY_FLAG_EN to add a registered carry/borrow flag on c.
module microc_stack
  import microc_pkg::*;
#(
  parameter int DW          = 8,
  parameter int PCW         = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PCW-1:0]      pc,
  input  logic [IW-1:0]       instr,
  output logic [OPCODE_W-1:0] Opcode,
  output logic                z,
  output logic                c,
  input  logic                s_inc,
  input  logic                s_inm,
  input  logic                we3,
  input  logic                wez,
  input  logic [2:0]          Op,
  input  logic                s_call,
  input  logic                s_ret,
  output logic                stk_full,
  output logic                stk_empty,
  output logic                stk_err
);
  logic [RA_W-1:0] ra1, ra2, wa3;
  logic [DW-1:0]   imm, rd1, rd2, wd3, res, sum, diff;
  logic [DW-1:0]   rf [NREGS];
  logic [PCW-1:0]  pc_inc, pc_next, target, stk_top;

  assign Opcode = instr[OPCODE_LSB +: OPCODE_W];
  assign ra1    = instr[RA1_LSB +: RA_W];
  assign ra2    = instr[RA2_LSB +: RA_W];
  assign wa3    = instr[WA3_LSB +: RA_W];
  assign imm    = DW'(instr[IMM_LSB +: IMM_W]);
  assign target = instr[PCW-1:0];

  // Register file: async reads see the pre-edge value on same-address writes.
  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];
  assign wd3 = s_inm ? imm : res;

  always_ff @(posedge clk) begin
    if (we3) rf[wa3] <= wd3;
  end

`ifdef MICROC_CARRY_FLAG_EN
  logic [DW:0] add_w, sub_w;
  logic        c_next;
  assign add_w  = {1'b0, rd1} + {1'b0, rd2};
  assign sub_w  = {1'b0, rd1} - {1'b0, rd2};
  assign sum    = add_w[DW-1:0];
  assign diff   = sub_w[DW-1:0];
  // sub_w[DW] is set exactly when rd1 < rd2, i.e. the borrow.
  assign c_next = (Op == ALU_ADD) ? add_w[DW] : (Op == ALU_SUB) ? sub_w[DW] : 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   c <= 1'b0;
    else if (wez) c <= c_next;
  end
`else
  assign sum  = rd1 + rd2;
  assign diff = rd1 - rd2;
  assign c    = 1'b0;
`endif

  always_comb begin
    res = rd1;
    unique case (Op)
      ALU_PASSA: res = rd1;
      ALU_NOTA:  res = ~rd1;
      ALU_ADD:   res = sum;
      ALU_SUB:   res = diff;
      ALU_AND:   res = rd1 & rd2;
      ALU_OR:    res = rd1 | rd2;
      ALU_NEGA:  res = -rd1;
      ALU_NEGB:  res = -rd2;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   z <= 1'b0;
    else if (wez) z <= (res == '0);
  end

  assign pc_inc = pc + PCW'(1);

  // RET beats CALL; a RET on an empty stack falls through to the next instruction.
  always_comb begin
    pc_next = pc_inc;
    if (s_ret)                 pc_next = stk_empty ? pc_inc : stk_top;
    else if (s_call || !s_inc) pc_next = target;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= '0;
    else        pc <= pc_next;
  end

  pc_stack #(.PCW(PCW), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (s_call),
    .pop       (s_ret),
    .push_data (pc_inc),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .err       (stk_err)
  );
endmodule
